dfp_arbiter: RTL and testbench
==============================

# dfp_arbiter

- Two-port line-transfer arbiter that sits directly upstream of the cache-to-burst-memory adapter.
- Merges the I-cache miss port (read-only) and the D-cache miss/writeback port (read and write) onto the single 256-bit DFP interface.
- Runs exactly one transaction at a time and routes each response back to the requester that owns it.
- Fairness between the two caches is round-robin.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits
- OFFSET_W, 5, line offset bits; these are forced to zero on the outgoing address

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- i_dfp_addr  in  ADDR_W  I-cache line address
- i_dfp_read  in  1  I-cache read request; level, held until i_dfp_resp
- i_dfp_rdata  out  LINE_W  line returned to the I-cache
- i_dfp_resp  out  1  one-cycle completion pulse to the I-cache
- d_dfp_addr  in  ADDR_W  D-cache line address
- d_dfp_read  in  1  D-cache read request; level
- d_dfp_write  in  1  D-cache writeback request; level
- d_dfp_wdata  in  LINE_W  writeback line
- d_dfp_rdata  out  LINE_W  line returned to the D-cache
- d_dfp_resp  out  1  one-cycle completion pulse to the D-cache
- dfp_addr  out  ADDR_W  line-aligned address to the adapter
- dfp_read  out  1  read issue, single-cycle pulse
- dfp_write  out  1  write burst enable, held until dfp_w_resp
- dfp_wdata  out  LINE_W  latched writeback line
- dfp_rdata  in  LINE_W  returned line
- dfp_raddr  in  ADDR_W  address tag of the returned line
- dfp_r_resp  in  1  read complete
- dfp_w_resp  in  1  write complete; asserted during the 4th beat

## Operation
State machine states: IDLE, RD_ISSUE, RD_WAIT, WR_BURST.

- **IDLE**
  - Samples the requests.
  - Candidate I = i_dfp_read.
  - Candidate D = d_dfp_write | d_dfp_read.
  - If both candidates are present, grant goes to the port not granted last. The last-grant pointer resets to I, so D wins the first tie.
  - On grant, latch: owner, {addr[ADDR_W-1:OFFSET_W], OFFSET_W'0}, operation and d_dfp_wdata.
  - A D read goes to RD_ISSUE; a D write goes to WR_BURST.
  - If d_dfp_write and d_dfp_read are both high, the write wins (protocol violation, flagged by a bench assertion).
- **RD_ISSUE**
  - dfp_read=1 for exactly this cycle.
  - Next state is RD_WAIT.
- **RD_WAIT**
  - dfp_read=0.
  - On an accepted dfp_r_resp:
    - owner's resp=1 combinationally in the same cycle;
    - owner's rdata = dfp_rdata;
    - next state is IDLE.
- **WR_BURST**
  - dfp_write=1 and dfp_wdata = latched line every cycle.
  - On dfp_w_resp:
    - d_dfp_resp=1 in the same cycle;
    - next state is IDLE, so dfp_write drops on the following cycle.
- Non-owner resp is always 0. The rdata outputs carry dfp_rdata unconditionally; only resp qualifies them.
- A requester that drops its request mid-transaction does not abort the transaction: the transfer completes and resp still pulses.
- In IDLE, dfp_r_resp and dfp_w_resp are ignored, including stray responses from before a reset.

## Timing
- Reset value of every state bit and output: state=IDLE, dfp_read=0, dfp_write=0, i_dfp_resp=0, d_dfp_resp=0, last-grant=I, dfp_addr=0, dfp_wdata=0.
- Reset asserted mid-transaction returns to IDLE immediately, with no resp issued.
- Read request high in IDLE at cycle N:
  - dfp_read is high in N+1;
  - resp arrives in the cycle dfp_r_resp arrives (adapter-determined, minimum N+2).
- Write request in IDLE at cycle N:
  - dfp_write is high from N+1 through the w_resp cycle, nominally 4 cycles, N+1..N+4;
  - d_dfp_resp is high at N+4.
- After a resp, the FSM spends at least one IDLE cycle before the next grant. A request still high in that cycle is re-granted, so each cache must drop its request on the edge after resp.
- dfp_addr, dfp_wdata and the owner bit are stable from grant until return to IDLE.

## Configuration
- DFP_ARB_ADDR_CHECK_EN defined:
  - in RD_WAIT, dfp_r_resp is accepted only when dfp_raddr equals the latched line address;
  - a mismatching response is dropped, and the FSM stays in RD_WAIT.
- DFP_ARB_ADDR_CHECK_EN undefined:
  - any dfp_r_resp in RD_WAIT is accepted;
  - dfp_raddr is unused.

## Structure
- Shared package holds:
  - the state enum (IDLE, RD_ISSUE, RD_WAIT, WR_BURST);
  - the owner enum (OWN_I, OWN_D);
  - the line-width and offset constants, shared with the caches and adapter.
- One sub-module: rr_grant2.
  - Two-requester round-robin picker with a last-grant register.
  - Advanced only on a grant.

## Test plan
1. I read alone:
   - Stimulus: i_dfp_addr=0x0000_1234.
   - Response: dfp_addr=0x0000_1220 and a 1-cycle dfp_read. Returning r_resp with raddr=0x0000_1220 and rdata=0xA5…A5 gives i_dfp_resp=1, i_dfp_rdata=0xA5…A5, and d_dfp_resp=0.
2. D writeback:
   - Stimulus: d_dfp_addr=0x8000_0040 with wdata pattern {4{64'hDEAD_BEEF_0000_000k}}.
   - Response: dfp_write high for 4 cycles with stable wdata; d_dfp_resp is high in the w_resp cycle and dfp_write=0 on the next cycle.
3. Simultaneous requests:
   - Stimulus: I and D held continuously from reset.
   - Response: grant order is D, I, D, I; each completes with only its own resp.
4. Address check (macro on):
   - Stimulus: r_resp with raddr=0x0000_2000 while waiting on 0x0000_1220.
   - Response: ignored. A later correct raddr completes the read.
   - With the macro off, the first response completes the read.
5. Reset mid-read:
   - Stimulus: rst low in RD_WAIT.
   - Response: all outputs return to reset values. A late dfp_r_resp after reset release produces no resp.
6. Read and write simultaneously on the D port:
   - Response: the write is performed and dfp_read is never pulsed.

Source files
------------

// File: rtl/dfp_arbiter_pkg.sv
// Shared types and line geometry for the DFP arbiter, caches and burst adapter.
package dfp_arbiter_pkg;

    localparam int DFP_ADDR_W   = 32;
    localparam int DFP_LINE_W   = 256;
    localparam int DFP_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/dfp_arbiter_if.sv
// Bundle of the I-cache, D-cache and adapter-side DFP signals.
// slave: arbiter view; master: the surrounding caches/adapter view.
interface dfp_arbiter_if #(
    parameter int ADDR_W = dfp_arbiter_pkg::DFP_ADDR_W,
    parameter int LINE_W = dfp_arbiter_pkg::DFP_LINE_W
);
    logic [ADDR_W-1:0] i_dfp_addr;
    logic              i_dfp_read;
    logic [LINE_W-1:0] i_dfp_rdata;
    logic              i_dfp_resp;

    logic [ADDR_W-1:0] d_dfp_addr;
    logic              d_dfp_read;
    logic              d_dfp_write;
    logic [LINE_W-1:0] d_dfp_wdata;
    logic [LINE_W-1:0] d_dfp_rdata;
    logic              d_dfp_resp;

    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic [ADDR_W-1:0] dfp_raddr;
    logic              dfp_r_resp;
    logic              dfp_w_resp;

    modport slave (
        input  i_dfp_addr, i_dfp_read,
        output i_dfp_rdata, i_dfp_resp,
        input  d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        output d_dfp_rdata, d_dfp_resp,
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_raddr, dfp_r_resp, dfp_w_resp
    );

    modport master (
        output i_dfp_addr, i_dfp_read,
        input  i_dfp_rdata, i_dfp_resp,
        output d_dfp_addr, d_dfp_read, d_dfp_write, d_dfp_wdata,
        input  d_dfp_rdata, d_dfp_resp,
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_raddr, dfp_r_resp, dfp_w_resp
    );

endinterface

// File: rtl/dfp_arbiter_rr_grant2.sv
// Two-requester round-robin picker; the last-grant pointer moves only when a grant is taken.
module rr_grant2
    import dfp_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_icache,
    input  logic   req_dcache,
    input  logic   advance,
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    owner_t last_q;

    // Pointer resets to I so the first tie goes to D.
    always_comb begin
        gnt_valid = req_icache | req_dcache;
        gnt_owner = OWN_I;
        if (req_icache && req_dcache) begin
            gnt_owner = (last_q == OWN_I) ? OWN_D : OWN_I;
        end else if (req_dcache) begin
            gnt_owner = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_I;
        end else if (advance && gnt_valid) begin
            last_q <= gnt_owner;
        end
    end

endmodule

// File: rtl/dfp_arbiter.sv
// Merges I-cache and D-cache line transfers onto one DFP port, one transaction at a time.
// Optional DFP_ARB_ADDR_CHECK_EN: accept read responses only when dfp_raddr matches the request.
module dfp_arbiter
    import dfp_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DFP_ADDR_W,
    parameter int LINE_W   = DFP_LINE_W,
    parameter int OFFSET_W = DFP_OFFSET_W
) (
    input  logic          clk,
    input  logic          rst,
    dfp_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic              gnt_valid;
    owner_t            gnt_owner;
    logic              req_dcache;
    logic              grant;
    logic              r_accept;
    logic [ADDR_W-1:0] sel_addr;

    assign req_dcache = bus.d_dfp_write | bus.d_dfp_read;
    assign grant      = (state_q == IDLE) && gnt_valid;
    assign sel_addr   = (gnt_owner == OWN_D) ? bus.d_dfp_addr : bus.i_dfp_addr;

    rr_grant2 u_rr_grant2 (
        .clk        (clk),
        .rst        (rst),
        .req_icache (bus.i_dfp_read),
        .req_dcache (req_dcache),
        .advance    (state_q == IDLE),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

`ifdef DFP_ARB_ADDR_CHECK_EN
    assign r_accept = bus.dfp_r_resp && (bus.dfp_raddr == addr_q);
    logic unused_bits;
    assign unused_bits = ^{bus.i_dfp_addr[OFFSET_W-1:0], bus.d_dfp_addr[OFFSET_W-1:0]};
`else
    assign r_accept = bus.dfp_r_resp;
    logic unused_bits;
    assign unused_bits = ^{bus.i_dfp_addr[OFFSET_W-1:0], bus.d_dfp_addr[OFFSET_W-1:0],
                           bus.dfp_raddr};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= gnt_owner;
                addr_q  <= {sel_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                wdata_q <= bus.d_dfp_wdata;
            end
        end
    end

    // A D-port request with both read and write high is treated as a write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = (gnt_owner == OWN_D && bus.d_dfp_write) ? WR_BURST : RD_ISSUE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (r_accept) state_d = IDLE;
            end
            WR_BURST: begin
                if (bus.dfp_w_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.dfp_read    = (state_q == RD_ISSUE);
        bus.dfp_write   = (state_q == WR_BURST);
        bus.dfp_addr    = addr_q;
        bus.dfp_wdata   = wdata_q;
        bus.i_dfp_rdata = bus.dfp_rdata;
        bus.d_dfp_rdata = bus.dfp_rdata;
        bus.i_dfp_resp  = (state_q == RD_WAIT) && r_accept && (owner_q == OWN_I);
        bus.d_dfp_resp  = ((state_q == RD_WAIT) && r_accept && (owner_q == OWN_D))
                        || ((state_q == WR_BURST) && bus.dfp_w_resp);
    end

endmodule

// File: tb/tb_dfp_arbiter.sv
// Scoreboard bench for dfp_arbiter: stimulus queues expected issues/responses, monitors pop and compare.
`timescale 1ns/1ps
module tb_dfp_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam bit P_I = 1'b0;
    localparam bit P_D = 1'b1;

    typedef struct packed {
        logic          own;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dfp_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    dfp_arbiter #(.ADDR_W(AW), .LINE_W(LW), .OFFSET_W(5)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    item_t iss_q[$];
    item_t rsp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    resp_seen = 0;
    bit    adapter_en = 1'b1;
    bit    bad_raddr = 1'b0;
    int    stray_req = 0;

    function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic logic [LW-1:0] exp_line(logic [AW-1:0] a);
        if (a == 32'h0000_1220) return {32{8'hA5}};
        return {8{a}};
    endfunction

    function automatic item_t mk(bit own, bit wr, logic [AW-1:0] a, logic [LW-1:0] d);
        item_t t;
        t.own = own; t.wr = wr; t.addr = a; t.data = d;
        return t;
    endfunction

    // Response monitor
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (bus.i_dfp_resp || bus.d_dfp_resp) begin
                resp_seen++;
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got i=%0b d=%0b want none", bus.i_dfp_resp, bus.d_dfp_resp);
                end else begin
                    e = rsp_q.pop_front();
                    chk("resp_owner", LW'(bus.d_dfp_resp), LW'(e.own));
                    chk("resp_exclusive", LW'(bus.i_dfp_resp & bus.d_dfp_resp), '0);
                    if (e.wr) chk("write_active_at_resp", LW'(bus.dfp_write), LW'(1'b1));
                    else      chk("resp_rdata", e.own ? bus.d_dfp_rdata : bus.i_dfp_rdata, e.data);
                end
            end
        end
    end

    // Issue monitor
    initial begin
        item_t e;
        item_t cur_wr;
        logic  prev_read;
        logic  prev_ovl;
        bit    in_wr;
        int    beats;
        prev_read = 1'b0; prev_ovl = 1'b0; in_wr = 1'b0; beats = 0; cur_wr = '0;
        forever begin
            @(negedge clk);
            if (bus.dfp_read) begin
                chk("read_single_cycle", LW'(prev_read), '0);
                chk("read_write_excl", LW'(bus.dfp_write), '0);
                if (iss_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %h want no issue", bus.dfp_addr);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_op_read", LW'(bus.dfp_write), LW'(e.wr));
                    chk("read_addr", LW'(bus.dfp_addr), LW'(e.addr));
                end
            end
            if (bus.dfp_write) begin
                if (!in_wr) begin
                    in_wr = 1'b1;
                    beats = 0;
                    if (iss_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got addr %h want no issue", bus.dfp_addr);
                        cur_wr = '0;
                    end else begin
                        cur_wr = iss_q.pop_front();
                        chk("issue_op_write", LW'(bus.dfp_write), LW'(cur_wr.wr));
                    end
                end
                beats++;
                chk("write_addr", LW'(bus.dfp_addr), LW'(cur_wr.addr));
                chk("wdata_stable", bus.dfp_wdata, cur_wr.data);
            end else if (in_wr) begin
                chk("write_beats", LW'(beats), LW'(4));
                in_wr = 1'b0;
            end
            if (bus.d_dfp_read && bus.d_dfp_write && !prev_ovl)
                $display("note: d_dfp_read and d_dfp_write both high at %0t (protocol violation)", $time);
            prev_ovl  = bus.d_dfp_read & bus.d_dfp_write;
            prev_read = bus.dfp_read;
        end
    end

    // Adapter model
    initial begin
        logic [AW-1:0] a;
        int stray_done;
        stray_done = 0;
        bus.dfp_r_resp = 1'b0;
        bus.dfp_w_resp = 1'b0;
        bus.dfp_raddr  = '0;
        bus.dfp_rdata  = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                @(posedge clk); #1;
                bus.dfp_raddr = 32'h0000_1220; bus.dfp_rdata = {32{8'hA5}}; bus.dfp_r_resp = 1'b1;
                @(posedge clk); #1;
                bus.dfp_r_resp = 1'b0;
            end else if (adapter_en && bus.dfp_read) begin
                a = bus.dfp_addr;
                @(posedge clk); #1;
                if (bad_raddr) begin
                    bus.dfp_raddr = 32'h0000_2000; bus.dfp_rdata = {32{8'h5A}}; bus.dfp_r_resp = 1'b1;
                    @(posedge clk); #1;
                    bus.dfp_r_resp = 1'b0;
`ifdef DFP_ARB_ADDR_CHECK_EN
                    @(posedge clk); #1;
                    bus.dfp_raddr = a; bus.dfp_rdata = exp_line(a); bus.dfp_r_resp = 1'b1;
                    @(posedge clk); #1;
                    bus.dfp_r_resp = 1'b0;
`endif
                end else begin
                    bus.dfp_raddr = a; bus.dfp_rdata = exp_line(a); bus.dfp_r_resp = 1'b1;
                    @(posedge clk); #1;
                    bus.dfp_r_resp = 1'b0;
                end
            end else if (adapter_en && bus.dfp_write) begin
                repeat (3) @(posedge clk);
                #1 bus.dfp_w_resp = 1'b1;
                @(posedge clk); #1;
                bus.dfp_w_resp = 1'b0;
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_resps(int n);
        int base;
        int cyc;
        base = resp_seen;
        cyc = 0;
        while (resp_seen < base + n && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (resp_seen < base + n) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got %0d responses want %0d", resp_seen - base, n);
        end
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_dfp_read"},  LW'(bus.dfp_read), '0);
        chk({tag, "_dfp_write"}, LW'(bus.dfp_write), '0);
        chk({tag, "_i_resp"},    LW'(bus.i_dfp_resp), '0);
        chk({tag, "_d_resp"},    LW'(bus.d_dfp_resp), '0);
        chk({tag, "_dfp_addr"},  LW'(bus.dfp_addr), '0);
        chk({tag, "_dfp_wdata"}, bus.dfp_wdata, '0);
    endtask

    initial begin
        logic [LW-1:0] w;
        int base;
        // Both caches request from reset onward; D must win the first tie.
        bus.i_dfp_addr  = 32'h0000_3010;
        bus.i_dfp_read  = 1'b1;
        bus.d_dfp_addr  = 32'h4000_0085;
        bus.d_dfp_read  = 1'b1;
        bus.d_dfp_write = 1'b0;
        bus.d_dfp_wdata = {8{32'h1111_2222}};
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                iss_q.push_back(mk(P_D, 1'b0, 32'h4000_0080, '0));
                rsp_q.push_back(mk(P_D, 1'b0, 32'h4000_0080, {8{32'h4000_0080}}));
            end else begin
                iss_q.push_back(mk(P_I, 1'b0, 32'h0000_3000, '0));
                rsp_q.push_back(mk(P_I, 1'b0, 32'h0000_3000, {8{32'h0000_3000}}));
            end
        end
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_resps(4);
        bus.i_dfp_read = 1'b0;
        bus.d_dfp_read = 1'b0;
        idle(2);

        // I read alone
        iss_q.push_back(mk(P_I, 1'b0, 32'h0000_1220, '0));
        rsp_q.push_back(mk(P_I, 1'b0, 32'h0000_1220, {32{8'hA5}}));
        bus.i_dfp_addr = 32'h0000_1234;
        bus.i_dfp_read = 1'b1;
        wait_resps(1);
        bus.i_dfp_read = 1'b0;
        idle(2);

        // D writeback; wdata input changes after grant to prove the line is latched
        w = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
             64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
        iss_q.push_back(mk(P_D, 1'b1, 32'h8000_0040, w));
        rsp_q.push_back(mk(P_D, 1'b1, 32'h8000_0040, '0));
        bus.d_dfp_addr  = 32'h8000_0040;
        bus.d_dfp_wdata = w;
        bus.d_dfp_write = 1'b1;
        idle(1);
        bus.d_dfp_wdata = {LW{1'b1}};
        wait_resps(1);
        bus.d_dfp_write = 1'b0;
        idle(2);

        // Response tagged with the wrong address
        bad_raddr = 1'b1;
        iss_q.push_back(mk(P_I, 1'b0, 32'h0000_1220, '0));
`ifdef DFP_ARB_ADDR_CHECK_EN
        rsp_q.push_back(mk(P_I, 1'b0, 32'h0000_1220, {32{8'hA5}}));
`else
        rsp_q.push_back(mk(P_I, 1'b0, 32'h0000_1220, {32{8'h5A}}));
`endif
        bus.i_dfp_addr = 32'h0000_1234;
        bus.i_dfp_read = 1'b1;
        wait_resps(1);
        bus.i_dfp_read = 1'b0;
        bad_raddr = 1'b0;
        idle(4);

        // D read and write together: write wins, no read pulse
        w = {8{32'hC0FF_EE00}};
        iss_q.push_back(mk(P_D, 1'b1, 32'h8000_1000, w));
        rsp_q.push_back(mk(P_D, 1'b1, 32'h8000_1000, '0));
        bus.d_dfp_addr  = 32'h8000_1000;
        bus.d_dfp_wdata = w;
        bus.d_dfp_read  = 1'b1;
        bus.d_dfp_write = 1'b1;
        wait_resps(1);
        bus.d_dfp_read  = 1'b0;
        bus.d_dfp_write = 1'b0;
        idle(2);

        // Reset while waiting for read data, then a stray response in IDLE
        adapter_en = 1'b0;
        iss_q.push_back(mk(P_I, 1'b0, 32'h0000_1220, '0));
        bus.i_dfp_addr = 32'h0000_1234;
        bus.i_dfp_read = 1'b1;
        idle(4);
        rst_n = 1'b0;
        bus.i_dfp_read = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        idle(2);
        rst_n = 1'b1;
        base = resp_seen;
        stray_req++;
        idle(6);
        chk("stray_resp_ignored", LW'(resp_seen), LW'(base));
        adapter_en = 1'b1;

        // Last-grant pointer is back at I after reset: D wins the tie again
        iss_q.push_back(mk(P_D, 1'b0, 32'h4000_0080, '0));
        rsp_q.push_back(mk(P_D, 1'b0, 32'h4000_0080, {8{32'h4000_0080}}));
        iss_q.push_back(mk(P_I, 1'b0, 32'h0000_3000, '0));
        rsp_q.push_back(mk(P_I, 1'b0, 32'h0000_3000, {8{32'h0000_3000}}));
        bus.i_dfp_addr = 32'h0000_3010;
        bus.d_dfp_addr = 32'h4000_0085;
        bus.i_dfp_read = 1'b1;
        bus.d_dfp_read = 1'b1;
        wait_resps(2);
        bus.i_dfp_read = 1'b0;
        bus.d_dfp_read = 1'b0;
        idle(4);

        chk("issue_queue_drained", LW'(iss_q.size()), '0);
        chk("resp_queue_drained", LW'(rsp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
